// File: rtl/dram_port_arbiter.sv
// Round-robin sharing of the single DRAM user port among NUM_REQ requesters; issue is combinational.
// Read returns come back in issue order and are steered to their requester through an ID FIFO.
module dram_port_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 128,
  parameter int MASK_WIDTH = 16,
  parameter int TAG_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req_ren,
  input  logic [NUM_REQ-1:0]            i_req_wen,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  input  logic [NUM_REQ*MASK_WIDTH-1:0] i_req_mask,
  output logic [NUM_REQ-1:0]            o_req_ack,
  output logic [DATA_WIDTH-1:0]         o_rd_data,
  output logic [NUM_REQ-1:0]            o_rd_valid,
  output logic                          o_dram_ren,
  output logic                          o_dram_wen,
  output logic [ADDR_WIDTH-1:0]         o_dram_addr,
  output logic [DATA_WIDTH-1:0]         o_dram_data,
  output logic [MASK_WIDTH-1:0]         o_dram_mask,
  input  logic                          i_dram_busy,
  input  logic [DATA_WIDTH-1:0]         i_dram_data,
  input  logic                          i_dram_valid,
  output logic [$clog2(TAG_DEPTH):0]    o_pending,
  output logic                          o_err
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int PTW = $clog2(TAG_DEPTH);
  localparam int PW  = PTW + 1;

  logic [IDW-1:0]     last_q, last_d;
  logic [IDW-1:0]     id_mem_q [TAG_DEPTH];
  logic [PTW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PW-1:0]      pending_q, pending_d;
  logic               err_q;
  logic [NUM_REQ-1:0] elig;
  logic [IDW-1:0]     win, idx;
  logic               found, issue, push, pop;

  // A read is only eligible while there is room to remember who issued it.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      elig[k] = i_req_wen[k] | (i_req_ren[k] & (pending_q < PW'(TAG_DEPTH)));
    end
  end

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IDW'((int'(last_q) + i) % NUM_REQ);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign issue       = found & ~i_dram_busy & ~i_rst;
  assign o_req_ack   = issue ? (NUM_REQ'(1) << win) : '0;
  assign o_dram_wen  = issue & i_req_wen[win];
  assign o_dram_ren  = issue & ~i_req_wen[win];
  assign o_dram_addr = i_req_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
  assign o_dram_data = i_req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
  assign o_dram_mask = i_req_mask[int'(win)*MASK_WIDTH +: MASK_WIDTH];

  assign push       = o_dram_ren;
  assign pop        = i_dram_valid & (pending_q != '0) & ~i_rst;
  assign o_rd_valid = pop ? (NUM_REQ'(1) << id_mem_q[rd_ptr_q]) : '0;
  assign o_rd_data  = i_dram_data;
  assign o_pending  = pending_q;
  assign o_err      = err_q;

  always_comb begin
    pending_d = pending_q + {{(PW-1){1'b0}}, push} - {{(PW-1){1'b0}}, pop};
    last_d    = issue ? win : last_q;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      last_q    <= IDW'(NUM_REQ - 1);
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      last_q    <= last_d;
      pending_q <= pending_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      // A return with nothing outstanding means the wrapper and this block disagree.
      if (i_dram_valid && pending_q == '0) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) id_mem_q[wr_ptr_q] <= win;
  end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed and random stimulus for dram_port_arbiter, checked against a queue-based model.
module tb_dram_port_arbiter;
  localparam int N  = 2;
  localparam int AW = 27;
  localparam int DW = 128;
  localparam int MW = 16;
  localparam int TD = 16;
  localparam int PW = $clog2(TD) + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    ren, wen;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N*MW-1:0] mask;
  logic [N-1:0]    ack, rd_valid;
  logic [DW-1:0]   rd_data;
  logic            dram_ren, dram_wen;
  logic [AW-1:0]   dram_addr;
  logic [DW-1:0]   dram_data;
  logic [MW-1:0]   dram_mask;
  logic            busy, dvalid;
  logic [DW-1:0]   ddata;
  logic [PW-1:0]   pending;
  logic            err;

  dram_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                      .MASK_WIDTH(MW), .TAG_DEPTH(TD)) dut (
    .clk(clk), .i_rst(rst),
    .i_req_ren(ren), .i_req_wen(wen), .i_req_addr(addr), .i_req_data(wdata), .i_req_mask(mask),
    .o_req_ack(ack), .o_rd_data(rd_data), .o_rd_valid(rd_valid),
    .o_dram_ren(dram_ren), .o_dram_wen(dram_wen), .o_dram_addr(dram_addr),
    .o_dram_data(dram_data), .o_dram_mask(dram_mask),
    .i_dram_busy(busy), .i_dram_data(ddata), .i_dram_valid(dvalid),
    .o_pending(pending), .o_err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: outstanding read owners in issue order, last granted index, sticky error.
  int q[$];
  int last  = N - 1;
  bit err_m = 1'b0;
  logic [N-1:0] obs_ack, obs_rv;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called just after a rising edge with inputs already driven; covers one full clock.
  task automatic step();
    int w;
    bit iss, e_wen, e_ren;
    logic [N-1:0] e_ack, e_rv;
    w = -1;
    for (int i = 1; i <= N; i++) begin
      int k;
      k = (last + i) % N;
      if (w < 0 && (wen[k] || (ren[k] && q.size() < TD))) w = k;
    end
    iss   = (w >= 0) && !busy && !rst;
    e_ack = iss ? (N'(1) << w) : '0;
    e_wen = iss ? wen[w] : 1'b0;
    e_ren = iss ? !wen[w] : 1'b0;
    e_rv  = (!rst && dvalid && q.size() > 0) ? (N'(1) << q[0]) : '0;
    @(negedge clk);
    obs_ack = ack;
    obs_rv  = rd_valid;
    chk("ack", DW'(ack), DW'(e_ack));
    chk("dram_wen", DW'(dram_wen), DW'(e_wen));
    chk("dram_ren", DW'(dram_ren), DW'(e_ren));
    chk("rd_valid", DW'(rd_valid), DW'(e_rv));
    if (iss) begin
      chk("dram_addr", DW'(dram_addr), DW'(addr[w*AW +: AW]));
      if (e_wen) begin
        chk("dram_data", dram_data, wdata[w*DW +: DW]);
        chk("dram_mask", DW'(dram_mask), DW'(mask[w*MW +: MW]));
      end
    end
    if (e_rv != '0) chk("rd_data", rd_data, ddata);
    @(posedge clk);
    if (rst) begin
      q.delete();
      err_m = 1'b0;
      last  = N - 1;
    end else begin
      if (dvalid) begin
        if (q.size() > 0) void'(q.pop_front());
        else err_m = 1'b1;
      end
      if (iss) last = w;
      if (e_ren) q.push_back(w);
    end
    #1;
    chk("pending", DW'(pending), DW'(q.size()));
    chk("err", DW'(err), DW'(err_m));
  endtask

  task automatic idle();
    ren = '0; wen = '0; busy = 1'b0; dvalid = 1'b0; rst = 1'b0;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < TD + 2 && q.size() > 0; i++) begin
      dvalid = 1'b1;
      ddata  = rnd128();
      step();
    end
    dvalid = 1'b0;
    chk("drain_empty", DW'(pending), DW'(0));
  endtask

  initial begin
    rst = 1'b1; ren = '0; wen = '0; busy = 1'b0; dvalid = 1'b0;
    addr = '0; wdata = '0; mask = '0; ddata = '0;
    @(posedge clk); #1;
    step();

    // Only requester 0 writes four beats.
    idle();
    for (int i = 0; i < 4; i++) begin
      wen = 2'b01;
      addr[0 +: AW] = AW'(i * 8);
      wdata = {rnd128(), rnd128()};
      mask  = N*MW'($urandom);
      step();
      chk("t1_ack", DW'(obs_ack), DW'(2'b01));
    end

    // Both read continuously from a fresh reset; grants and returns alternate.
    idle(); rst = 1'b1; step();
    idle();
    for (int i = 0; i < 6; i++) begin
      ren    = 2'b11;
      dvalid = (i >= 1);
      ddata  = rnd128();
      step();
      chk("t2_ack", DW'(obs_ack), DW'((i % 2 == 0) ? 2'b01 : 2'b10));
      if (i >= 1) chk("t2_rv", DW'(obs_rv), DW'((i % 2 == 1) ? 2'b01 : 2'b10));
    end
    drain();

    // Busy stalls everything; the first grant afterwards goes to the index after the last.
    idle();
    for (int i = 0; i < 5; i++) begin
      ren = 2'b11; wen = 2'b10; busy = 1'b1;
      step();
      chk("t3_stall", DW'(obs_ack), DW'(0));
    end
    busy = 1'b0;
    step();
    chk("t3_resume", DW'(obs_ack), DW'(2'b01));
    drain();

    // Fill the ID FIFO from requester 0.
    idle();
    for (int i = 0; i < TD; i++) begin
      ren = 2'b01;
      step();
    end
    chk("t4_full", DW'(pending), DW'(TD));
    ren = 2'b01; wen = 2'b10;
    step();
    chk("t4_write_when_full", DW'(obs_ack), DW'(2'b10));
    wen = 2'b00;
    step();
    chk("t4_read_blocked", DW'(obs_ack), DW'(0));
    dvalid = 1'b1; ddata = rnd128();
    step();
    chk("t4_pop_no_push", DW'(pending), DW'(TD - 1));
    step();
    chk("t4_push_pop", DW'(pending), DW'(TD - 1));
    dvalid = 1'b0;
    step();
    chk("t4_refull", DW'(pending), DW'(TD));
    drain();

    // Return with nothing outstanding sets the sticky error.
    idle(); dvalid = 1'b1; ddata = rnd128();
    step();
    chk("t5_rv", DW'(obs_rv), DW'(0));
    chk("t5_err", DW'(err), DW'(1));
    idle();
    for (int i = 0; i < 3; i++) step();
    chk("t5_sticky", DW'(err), DW'(1));

    // Reset with reads outstanding.
    idle();
    for (int i = 0; i < 5; i++) begin
      ren = 2'b01;
      step();
    end
    chk("t6_pend5", DW'(pending), DW'(5));
    idle(); ren = 2'b11; rst = 1'b1;
    step();
    chk("t6_pend0", DW'(pending), DW'(0));
    chk("t6_err0", DW'(err), DW'(0));
    rst = 1'b0;
    step();
    chk("t6_first", DW'(obs_ack), DW'(2'b01));
    drain();

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      ren    = N'($urandom);
      wen    = N'($urandom) & N'($urandom);
      busy   = ($urandom_range(0, 3) == 0);
      dvalid = ($urandom_range(0, 9) < 4);
      rst    = ($urandom_range(0, 99) == 0);
      addr   = {AW'($urandom), AW'($urandom)};
      wdata  = {rnd128(), rnd128()};
      mask   = {MW'($urandom), MW'($urandom)};
      ddata  = rnd128();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
